// File: rtl/irq_sequencer_pkg.sv
// Shared types and constants for the multi-source interrupt sequencer.
// Optional nesting support in the top is enabled with `define IRQ_NESTING_EN.
package irq_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_PUSH_FLG,
    ST_VECTOR,
    ST_SERVICE
  } irq_state_e;

  localparam logic [4:0] INT_OPC     = 5'b11111;
  localparam logic [2:0] FN_PUSH_HI  = 3'b001;
  localparam logic [2:0] FN_PUSH_LO  = 3'b010;
  localparam logic [2:0] FN_PUSH_FLG = 3'b011;

  // Injected context-save word: opcode, reserved byte, function code.
  typedef struct packed {
    logic [4:0] opc;
    logic [7:0] rsvd;
    logic [2:0] func;
  } inj_instr_t;

  function automatic logic [15:0] inj_word(input logic [2:0] fn);
    inj_instr_t w;
    w.opc  = INT_OPC;
    w.rsvd = '0;
    w.func = fn;
    return w;
  endfunction

endpackage

// File: rtl/irq_sequencer_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 has the highest priority.
module irq_prio_enc #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt front end: edge detect, mask, priority pick, context-save injection,
// vectoring and return-PC supply. `define IRQ_NESTING_EN enables preemption.
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int unsigned       N_SRC      = 4,
  parameter int unsigned       PC_W       = 32,
  parameter logic [PC_W-1:0]   VEC_BASE   = 'h20,
  parameter int unsigned       VEC_STRIDE = 2,
  parameter logic [N_SRC-1:0]  MASK_RST   = '0,
  parameter int unsigned       NEST_DEPTH = 2,
  localparam int unsigned      ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq,
  input  logic              mask_we,
  input  logic [N_SRC-1:0]  mask_wdata,
  input  logic [PC_W-1:0]   next_pc,
  input  logic              stall,
  input  logic              rti_retire,
  output logic              hold_fetch,
  output logic              inj_valid,
  output logic [15:0]       inj_instr,
  output logic              vec_valid,
  output logic [PC_W-1:0]   vec_pc,
  output logic              ret_valid,
  output logic [PC_W-1:0]   ret_pc,
  output logic [ID_W-1:0]   active_id,
  output logic [N_SRC-1:0]  pending
);

  irq_state_e        state_q, state_d;
  logic [N_SRC-1:0]  irq_q, pending_q, pending_d, mask_q, mask_d, clr;
  logic [PC_W-1:0]   saved_pc_q, saved_pc_d;
  logic [ID_W-1:0]   active_id_q, active_id_d;
  logic [N_SRC-1:0]  eligible;
  logic              win_valid;
  logic [ID_W-1:0]   win_idx;
  logic              accept;
  logic [PC_W-1:0]   vec_addr;

  assign eligible = pending_q & ~mask_q;
  assign vec_addr = VEC_BASE + PC_W'(active_id_q) * PC_W'(VEC_STRIDE);
  assign active_id = active_id_q;
  assign pending   = pending_q;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

`ifdef IRQ_NESTING_EN
  localparam int unsigned SP_W = $clog2(NEST_DEPTH + 1);
  localparam int unsigned SI_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [PC_W-1:0] stk_pc_q [NEST_DEPTH];
  logic [PC_W-1:0] stk_pc_d [NEST_DEPTH];
  logic [ID_W-1:0] stk_id_q [NEST_DEPTH];
  logic [ID_W-1:0] stk_id_d [NEST_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [SI_W-1:0] push_idx, pop_idx;

  assign push_idx = SI_W'(sp_q);
  assign pop_idx  = SI_W'(sp_q - SP_W'(1));
`endif

  always_comb begin
    state_d     = state_q;
    saved_pc_d  = saved_pc_q;
    active_id_d = active_id_q;
    accept      = 1'b0;
    clr         = '0;
    hold_fetch  = 1'b0;
    inj_valid   = 1'b0;
    inj_instr   = '0;
    vec_valid   = 1'b0;
    vec_pc      = '0;
    ret_valid   = 1'b0;
    ret_pc      = '0;
`ifdef IRQ_NESTING_EN
    stk_pc_d = stk_pc_q;
    stk_id_d = stk_id_q;
    sp_d     = sp_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_valid && !stall) accept = 1'b1;
      end
      ST_PUSH_HI: begin
        hold_fetch = 1'b1;
        inj_valid  = 1'b1;
        inj_instr  = inj_word(FN_PUSH_HI);
        if (!stall) state_d = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        hold_fetch = 1'b1;
        inj_valid  = 1'b1;
        inj_instr  = inj_word(FN_PUSH_LO);
        if (!stall) state_d = ST_PUSH_FLG;
      end
      ST_PUSH_FLG: begin
        hold_fetch = 1'b1;
        inj_valid  = 1'b1;
        inj_instr  = inj_word(FN_PUSH_FLG);
        if (!stall) state_d = ST_VECTOR;
      end
      ST_VECTOR: begin
        hold_fetch = 1'b1;
        vec_valid  = 1'b1;
        vec_pc     = vec_addr;
        state_d    = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (rti_retire) begin
          ret_valid = 1'b1;
          ret_pc    = saved_pc_q;
`ifdef IRQ_NESTING_EN
          // Return resumes the interrupted handler's context if one was stacked.
          if (sp_q != '0) begin
            sp_d        = sp_q - SP_W'(1);
            saved_pc_d  = stk_pc_q[pop_idx];
            active_id_d = stk_id_q[pop_idx];
          end else begin
            state_d = ST_IDLE;
          end
        end else if (win_valid && (win_idx < active_id_q) && !stall &&
                     (sp_q != SP_W'(NEST_DEPTH))) begin
          stk_pc_d[push_idx] = saved_pc_q;
          stk_id_d[push_idx] = active_id_q;
          sp_d               = sp_q + SP_W'(1);
          accept             = 1'b1;
        end
`else
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      saved_pc_d  = next_pc;
      active_id_d = win_idx;
      clr         = N_SRC'(1) << win_idx;
      state_d     = ST_PUSH_HI;
    end

    // A fresh edge in the acceptance cycle re-sets the bit being cleared.
    pending_d = (pending_q & ~clr) | (irq & ~irq_q);
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      irq_q       <= '0;
      pending_q   <= '0;
      mask_q      <= MASK_RST;
      saved_pc_q  <= '0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      saved_pc_q  <= saved_pc_d;
      active_id_q <= active_id_d;
    end
  end

`ifdef IRQ_NESTING_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
      for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
        stk_pc_q[i] <= '0;
        stk_id_q[i] <= '0;
      end
    end else begin
      sp_q     <= sp_d;
      stk_pc_q <= stk_pc_d;
      stk_id_q <= stk_id_d;
    end
  end
`endif

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: expected inject/vector/return events are
// queued with their due cycle and matched against DUT output at the falling edge.
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wdata = '0;
  logic [31:0] next_pc = '0;
  logic        stall = 1'b0;
  logic        rti_retire = 1'b0;
  logic        hold_fetch, inj_valid, vec_valid, ret_valid;
  logic [15:0] inj_instr;
  logic [31:0] vec_pc, ret_pc;
  logic [1:0]  active_id;
  logic [3:0]  pending;

  irq_sequencer #(
    .N_SRC      (4),
    .PC_W       (32),
    .VEC_BASE   (32'h0000_0020),
    .VEC_STRIDE (2),
    .MASK_RST   (4'b0000),
    .NEST_DEPTH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .next_pc    (next_pc),
    .stall      (stall),
    .rti_retire (rti_retire),
    .hold_fetch (hold_fetch),
    .inj_valid  (inj_valid),
    .inj_instr  (inj_instr),
    .vec_valid  (vec_valid),
    .vec_pc     (vec_pc),
    .ret_valid  (ret_valid),
    .ret_pc     (ret_pc),
    .active_id  (active_id),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          kind;   // 0 inject, 1 vector, 2 return
    logic [31:0] val;
    int unsigned due;
  } ev_t;
  ev_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_ev(input int kind, input logic [31:0] val, input int unsigned due);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic exp_seq(input int unsigned c0, input logic [31:0] vec);
    exp_ev(0, 32'hF801, c0);
    exp_ev(0, 32'hF802, c0 + 1);
    exp_ev(0, 32'hF803, c0 + 2);
    exp_ev(1, vec, c0 + 3);
  endtask

  task automatic obs(input int kind, input logic [31:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      check("spurious_event", 64'(kind + 1), 64'd0);
    end else begin
      e = sb.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      check("event_value", 64'(val), 64'(e.val));
      check("event_cycle", 64'(cyc), 64'(e.due));
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      check("missed_event_due", 64'(sb[0].due), 64'(cyc));
      void'(sb.pop_front());
    end
    if (inj_valid === 1'b1) obs(0, {16'h0, inj_instr});
    if (vec_valid === 1'b1) obs(1, vec_pc);
    if (ret_valid === 1'b1) obs(2, ret_pc);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({hold_fetch, inj_valid, vec_valid, ret_valid}), 64'd0);
    check({tag, "_words"}, 64'({inj_instr, vec_pc}), 64'd0);
    check({tag, "_ret"}, 64'({ret_pc, active_id, pending}), 64'd0);
  endtask

  int unsigned c0, r0;

  initial begin
    // Reset state
    reset = 1'b1;
    step(2);
    check_all_zero("reset");
    reset = 1'b0;
    step(1);

    // Single source 2: inject sequence, vector 0x24, return 0x100
    next_pc = 32'h100;
    irq[2] = 1'b1;
    c0 = cyc;
    exp_seq(c0 + 2, 32'h24);
    step(1);
    irq[2] = 1'b0;
    step(6);
    check("s1_active_id", 64'(active_id), 64'd2);
    check("s1_hold_in_service", 64'(hold_fetch), 64'd0);
    rti_retire = 1'b1;
    exp_ev(2, 32'h100, cyc);
    step(1);
    rti_retire = 1'b0;
    step(2);
    check("s1_pending_after", 64'(pending), 64'd0);

    // Simultaneous sources 1 and 3: 1 first, 3 after return
    next_pc = 32'h200;
    irq = 4'b1010;
    c0 = cyc;
    exp_seq(c0 + 2, 32'h22);
    step(1);
    irq = 4'b0000;
    step(6);
    check("s2_pending_held", 64'(pending), 64'b1000);
    check("s2_active_id", 64'(active_id), 64'd1);
    next_pc = 32'h300;
    rti_retire = 1'b1;
    r0 = cyc;
    exp_ev(2, 32'h200, r0);
    exp_seq(r0 + 2, 32'h26);
    step(1);
    rti_retire = 1'b0;
    step(6);
    check("s2_active_id_3", 64'(active_id), 64'd3);
    check("s2_pending_clear", 64'(pending), 64'd0);
    rti_retire = 1'b1;
    exp_ev(2, 32'h300, cyc);
    step(1);
    rti_retire = 1'b0;
    step(2);

    // Masked source 0 is retained, then accepted after unmask
    mask_we = 1'b1;
    mask_wdata = 4'b0001;
    step(1);
    mask_we = 1'b0;
    irq[0] = 1'b1;
    step(1);
    irq[0] = 1'b0;
    step(4);
    check("s3_masked_pending", 64'(pending), 64'b0001);
    check("s3_no_hold", 64'(hold_fetch), 64'd0);
    mask_we = 1'b1;
    mask_wdata = 4'b0000;
    c0 = cyc;
    exp_seq(c0 + 2, 32'h20);
    step(1);
    mask_we = 1'b0;
    step(6);
    rti_retire = 1'b1;
    exp_ev(2, 32'h300, cyc);
    step(1);
    rti_retire = 1'b0;
    step(2);

    // Stall during PUSH_LO holds the word and delays the vector
    next_pc = 32'h500;
    irq[1] = 1'b1;
    c0 = cyc;
    exp_ev(0, 32'hF801, c0 + 2);
    for (int i = 3; i <= 6; i++) exp_ev(0, 32'hF802, c0 + i);
    exp_ev(0, 32'hF803, c0 + 7);
    exp_ev(1, 32'h22, c0 + 8);
    step(1);
    irq[1] = 1'b0;
    step(2);
    stall = 1'b1;
    step(3);
    stall = 1'b0;
    step(4);
    rti_retire = 1'b1;
    exp_ev(2, 32'h500, cyc);
    step(1);
    rti_retire = 1'b0;
    step(2);

    // Reset during PUSH_FLG aborts; a later RTI produces nothing
    next_pc = 32'h600;
    irq[3] = 1'b1;
    c0 = cyc;
    exp_seq(c0 + 2, 32'h0);
    void'(sb.pop_back());
    step(1);
    irq[3] = 1'b0;
    step(1);
    irq[0] = 1'b1;
    step(1);
    irq[0] = 1'b0;
    step(1);
    check("s5_edge_during_seq", 64'(pending), 64'b0001);
    reset = 1'b1;
    step(1);
    check_all_zero("s5_abort");
    reset = 1'b0;
    step(1);
    rti_retire = 1'b1;
    #1;
    check("s5_no_ret", 64'(ret_valid), 64'd0);
    step(1);
    rti_retire = 1'b0;
    step(2);

    // Source 0 arriving while source 2 is in service
    next_pc = 32'h100;
    irq[2] = 1'b1;
    c0 = cyc;
    exp_seq(c0 + 2, 32'h24);
    step(1);
    irq[2] = 1'b0;
    step(6);
    next_pc = 32'h400;
    irq[0] = 1'b1;
`ifdef IRQ_NESTING_EN
    c0 = cyc;
    exp_seq(c0 + 2, 32'h20);
    step(1);
    irq[0] = 1'b0;
    step(6);
    check("n_active_preempt", 64'(active_id), 64'd0);
    rti_retire = 1'b1;
    exp_ev(2, 32'h400, cyc);
    step(1);
    rti_retire = 1'b0;
    step(1);
    check("n_active_restored", 64'(active_id), 64'd2);
    check("n_still_service", 64'(hold_fetch), 64'd0);
    rti_retire = 1'b1;
    exp_ev(2, 32'h100, cyc);
    step(1);
    rti_retire = 1'b0;
    step(2);
`else
    step(1);
    irq[0] = 1'b0;
    step(6);
    check("n_no_preempt_id", 64'(active_id), 64'd2);
    check("n_no_preempt_pend", 64'(pending), 64'b0001);
    rti_retire = 1'b1;
    r0 = cyc;
    exp_ev(2, 32'h100, r0);
    exp_seq(r0 + 2, 32'h20);
    step(1);
    rti_retire = 1'b0;
    step(6);
    rti_retire = 1'b1;
    exp_ev(2, 32'h400, cyc);
    step(1);
    rti_retire = 1'b0;
    step(2);
`endif
    check("final_pending", 64'(pending), 64'd0);

    step(3);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
Parametrised multi-source interrupt front end for the pipelined core. It replaces the single-line interrupt handler. It detects rising edges on N_SRC request lines, applies a software mask, and picks the highest-priority pending source. It then injects the context-save micro-instruction sequence into decode, redirects fetch to a per-source vector, and supplies the return PC when RTI retires. It sits between the fetch stage, the IF/ID buffer output mux and the PC select mux.

Parameters:
N_SRC, 4, number of interrupt request lines (1..16)
PC_W, 32, program-counter width
VEC_BASE, 32'h0000_0020, address of source-0 vector
VEC_STRIDE, 2, address distance between consecutive vectors
MASK_RST, all zeros, mask value after reset (1 = source disabled)
NEST_DEPTH, 2, saved-context depth; used only with IRQ_NESTING_EN

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
irq  in  N_SRC  level request lines; a rising edge raises a request
mask_we  in  1  write enable for the mask register
mask_wdata  in  N_SRC  new mask value
next_pc  in  PC_W  PC of the next sequential instruction in fetch
stall  in  1  decode cannot accept an injected instruction this cycle
rti_retire  in  1  one-cycle pulse when RTI leaves decode
hold_fetch  out  1  freeze fetch / select the injected instruction
inj_valid  out  1  inj_instr is valid this cycle
inj_instr  out  16  injected instruction word
vec_valid  out  1  one-cycle pulse: load vec_pc into PC
vec_pc  out  PC_W  vector address
ret_valid  out  1  one-cycle pulse: load ret_pc into PC
ret_pc  out  PC_W  saved return address
active_id  out  $clog2(N_SRC) (min 1)  source being serviced
pending  out  N_SRC  pending-request register

Behaviour:
- Reset (synchronous, active-high): state IDLE, pending=0, mask=MASK_RST, irq_q=0, saved PC=0, stack empty. All outputs 0.
- Edge detect: irq_q<=irq each cycle. Set pending[i] when irq[i]&~irq_q[i].
- Pending clear: pending[i] clears on acceptance. If a new edge on i arrives in the same cycle as its acceptance, the set wins and the bit stays 1.
- Mask: mask_we writes the mask at the clock edge. The new mask takes effect in the next cycle. Masked pending bits are retained, not dropped.
- Eligibility: eligible = pending & ~mask. Winner = lowest-index eligible bit (index 0 is highest priority).
- States are IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, VECTOR, SERVICE.
- IDLE: if eligible != 0 and stall = 0, then accept:
  - latch saved_pc=next_pc and active_id=winner;
  - clear pending[winner];
  - go to PUSH_HI.
- PUSH_HI / PUSH_LO / PUSH_FLG:
  - inj_valid=1 and hold_fetch=1;
  - inj_instr = {5'b11111, 8'h00, func}, with func 3'b001 (PUSH_HI), 3'b010 (PUSH_LO), 3'b011 (PUSH_FLG);
  - advance to the next state only when stall=0; otherwise hold the state and the word.
- VECTOR:
  - hold_fetch=1 and vec_valid=1 for exactly one cycle;
  - vec_pc = VEC_BASE + active_id*VEC_STRIDE, truncated to PC_W;
  - then go to SERVICE.
- Latency: irq edge to first inj_valid is 2 cycles with no stall (edge registered, then accepted). Accept to vec_valid is 4 cycles.
- SERVICE: no new acceptance (without nesting). On rti_retire: ret_valid=1 for one cycle with ret_pc=saved_pc, then go to IDLE.
- rti_retire outside SERVICE is ignored; ret_valid stays 0.
- A new edge during a sequence only sets pending. The source is serviced after return.
- Reset in any state aborts the sequence immediately. No ret_valid is produced.

Optional Feature:
IRQ_NESTING_EN
- Defined: in SERVICE, an eligible source with index < active_id preempts. Accept in the same way (requires stall=0) and push {saved_pc, active_id} onto a NEST_DEPTH-entry stack.
- When the stack is full, preemption is blocked.
- rti_retire pops the stack: ret_pc comes from the current context, the popped entry is restored, and the state stays SERVICE. The state goes to IDLE only when the stack is empty.
- Undefined: no stack logic. SERVICE never preempts.

Decomposition:
- Shared package holds:
  - state enum;
  - INT_OPC = 5'b11111;
  - func constants FN_PUSH_HI/FN_PUSH_LO/FN_PUSH_FLG;
  - the inj_instr field layout.
- One natural sub-module: irq_prio_enc (parametrised N_SRC lowest-index priority encoder, outputs valid + index).

Test Plan:
- irq[2] rises, stall=0, next_pc=0x100:
  - inj_instr 0xF801, 0xF802, 0xF803 on cycles 2..4;
  - vec_valid with vec_pc=0x24;
  - rti_retire gives ret_valid with ret_pc=0x100.
- irq[1] and irq[3] rise together: source 1 is serviced first (vec_pc=0x22). pending=4'b1000 until RTI, then source 3 is serviced (vec_pc=0x26).
- mask=4'b0001, irq[0] rises: no acceptance and pending[0]=1. Write mask=0: acceptance 1 cycle later.
- stall held high for 3 cycles during PUSH_LO: 0xF802 holds for 4 cycles. vec_valid is delayed by 3 cycles.
- reset asserted during PUSH_FLG: next cycle all outputs 0, state IDLE, pending=0. A later rti_retire produces no ret_valid.
- IRQ_NESTING_EN:
  - irq[0] during SERVICE of source 2 preempts (vec_pc=0x20);
  - first RTI returns to source 2's handler PC;
  - second RTI returns the original 0x100.
